// File: rtl/lzc_result_buf.sv
// lzc_result_buf
//   Result buffer that sits downstream of the leading-zero counter. Each
//   IVALID/ZEROS result is clamped to ZMAX_VAL and stored in a small FIFO
//   together with an all-zero flag. The head entry is offered to the consumer
//   over a valid/ready handshake. Results that arrive while the FIFO is full
//   are counted in DROPS, and an out-of-range ZEROS value sets the sticky ERR
//   flag.
//
//   Optional feature macro: LZC_STATS_EN
//     When defined, this block tracks the min, the max and the number of
//     accepted results (ZMIN/ZMAX/NRES). When undefined, those outputs are
//     tied to constants.
//
// Ports
//   CLK     in   1            clock, rising edge
//   RST_N   in   1            asynchronous active-low reset
//   IVALID  in   1            result strobe from the counter
//   ZEROS   in   9            leading-zero count from the counter
//   CLR     in   1            synchronous clear of FIFO, counters and flags
//   OVALID  out  1            head entry valid
//   OREADY  in   1            consumer accepts the head entry
//   OZEROS  out  9            head entry count (0 when empty)
//   OALLZ   out  1            head entry was an all-zero frame (0 when empty)
//   COUNT   out  log2(D)+1    occupancy
//   FULL    out  1            COUNT == DEPTH
//   DROPS   out  8            results dropped on overflow, saturating at 255
//   ERR     out  1            sticky, out-of-range ZEROS seen
//   ZMIN    out  9            minimum accepted count (stats)
//   ZMAX    out  9            maximum accepted count (stats)
//   NRES    out  11           accepted result count, saturating at 2047
module lzc_result_buf #(
  parameter int WIDTH = 4,
  parameter int WORD  = 4,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       IVALID,
  input  logic [8:0]                 ZEROS,
  input  logic                       CLR,
  output logic                       OVALID,
  input  logic                       OREADY,
  output logic [8:0]                 OZEROS,
  output logic                       OALLZ,
  output logic [$clog2(DEPTH):0]     COUNT,
  output logic                       FULL,
  output logic [7:0]                 DROPS,
  output logic                       ERR,
  output logic [8:0]                 ZMIN,
  output logic [8:0]                 ZMAX,
  output logic [10:0]                NRES
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [8:0] ZMAX_VAL = 9'(WIDTH * WORD);

  logic [8:0]    zq_r   [DEPTH];
  logic          allz_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic [7:0]    drops_r;
  logic          err_r;

  logic          empty_s;
  logic          full_s;
  logic          pop_s;
  logic          push_s;
  logic          drop_s;
  logic          oor_s;
  logic [8:0]    clamp_s;

  // Handshake decode: a pop frees a slot in the same cycle, so a push is
  // accepted at full occupancy whenever a pop happens alongside it.
  always_comb begin
    empty_s = (count_r == {(AW+1){1'b0}});
    full_s  = (count_r == (AW+1)'(DEPTH));
    pop_s   = !empty_s && OREADY;
    push_s  = IVALID && (!full_s || pop_s);
    drop_s  = IVALID && full_s && !pop_s;
    oor_s   = (ZEROS > ZMAX_VAL);
    if (oor_s) begin
      clamp_s = ZMAX_VAL;
    end else begin
      clamp_s = ZEROS;
    end
  end

  // Pointers and occupancy. CLR overrides any push or pop in the same cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else if (CLR) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage. Each entry holds the clamped count and its all-zero flag.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        zq_r[i]   <= 9'd0;
        allz_r[i] <= 1'b0;
      end
    end else if (push_s && !CLR) begin
      zq_r[wr_ptr_r]   <= clamp_s;
      allz_r[wr_ptr_r] <= (clamp_s == ZMAX_VAL);
    end
  end

  // Drop counter and sticky range-error flag. ERR is set by any out-of-range
  // strobe, including one that is dropped.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      drops_r <= 8'd0;
      err_r   <= 1'b0;
    end else if (CLR) begin
      drops_r <= 8'd0;
      err_r   <= 1'b0;
    end else begin
      if (drop_s && (drops_r != 8'd255)) begin
        drops_r <= drops_r + 8'd1;
      end
      if (IVALID && oor_s) begin
        err_r <= 1'b1;
      end
    end
  end

`ifdef LZC_STATS_EN
  logic [8:0]  zmin_r;
  logic [8:0]  zmax_r;
  logic [10:0] nres_r;

  // Statistics over accepted pushes only. Dropped results do not update them.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      zmin_r <= ZMAX_VAL;
      zmax_r <= 9'd0;
      nres_r <= 11'd0;
    end else if (CLR) begin
      zmin_r <= ZMAX_VAL;
      zmax_r <= 9'd0;
      nres_r <= 11'd0;
    end else if (push_s) begin
      if (clamp_s < zmin_r) begin
        zmin_r <= clamp_s;
      end
      if (clamp_s > zmax_r) begin
        zmax_r <= clamp_s;
      end
      if (nres_r != 11'd2047) begin
        nres_r <= nres_r + 11'd1;
      end
    end
  end

  assign ZMIN = zmin_r;
  assign ZMAX = zmax_r;
  assign NRES = nres_r;
`else
  assign ZMIN = ZMAX_VAL;
  assign ZMAX = 9'd0;
  assign NRES = 11'd0;
`endif

  // Output decode from registered state. Head data is forced to zero while
  // the FIFO is empty, so stale entries are never presented.
  always_comb begin
    OVALID = !empty_s;
    if (empty_s) begin
      OZEROS = 9'd0;
      OALLZ  = 1'b0;
    end else begin
      OZEROS = zq_r[rd_ptr_r];
      OALLZ  = allz_r[rd_ptr_r];
    end
  end

  assign COUNT = count_r;
  assign FULL  = full_s;
  assign DROPS = drops_r;
  assign ERR   = err_r;

endmodule

// File: tb/tb_lzc_result_buf.sv
// Self-checking bench for lzc_result_buf (WIDTH=4, WORD=4, DEPTH=4,
// ZMAX_VAL=16). A queue-based reference model is updated at every clock edge
// from the spec rules, and every output is compared one time unit after each edge.
module tb_lzc_result_buf;

  localparam int DEPTH = 4;
  localparam int ZMAXV = 16;

  logic        CLK;
  logic        RST_N;
  logic        IVALID;
  logic [8:0]  ZEROS;
  logic        CLR;
  logic        OVALID;
  logic        OREADY;
  logic [8:0]  OZEROS;
  logic        OALLZ;
  logic [2:0]  COUNT;
  logic        FULL;
  logic [7:0]  DROPS;
  logic        ERR;
  logic [8:0]  ZMIN;
  logic [8:0]  ZMAX;
  logic [10:0] NRES;

  int total = 0;
  int bad   = 0;

  // reference model state
  int q[$];
  int m_drops;
  int m_err;
  int m_zmin;
  int m_zmax;
  int m_nres;

  lzc_result_buf #(.WIDTH(4), .WORD(4), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N), .IVALID(IVALID), .ZEROS(ZEROS), .CLR(CLR),
    .OVALID(OVALID), .OREADY(OREADY), .OZEROS(OZEROS), .OALLZ(OALLZ),
    .COUNT(COUNT), .FULL(FULL), .DROPS(DROPS), .ERR(ERR),
    .ZMIN(ZMIN), .ZMAX(ZMAX), .NRES(NRES)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_drops = 0;
    m_err   = 0;
    m_zmin  = ZMAXV;
    m_zmax  = 0;
    m_nres  = 0;
  endtask

  task automatic model_edge(input bit iv, input int z, input bit rdy, input bit clr);
    int  cz;
    bit  full;
    bit  pop;
    if (clr) begin
      model_reset();
    end else begin
      full = (q.size() == DEPTH);
      pop  = (q.size() > 0) && rdy;
      cz   = (z > ZMAXV) ? ZMAXV : z;
      if (iv && z > ZMAXV) m_err = 1;
      if (pop) void'(q.pop_front());
      if (iv) begin
        if (!full || pop) begin
          q.push_back(cz);
          if (cz < m_zmin) m_zmin = cz;
          if (cz > m_zmax) m_zmax = cz;
          if (m_nres < 2047) m_nres++;
        end else if (m_drops < 255) begin
          m_drops++;
        end
      end
    end
  endtask

  task automatic check_all();
    int hz;
    hz = (q.size() > 0) ? q[0] : 0;
    check("ovalid", 32'(OVALID), 32'(q.size() > 0));
    check("ozeros", 32'(OZEROS), 32'(hz));
    check("oallz",  32'(OALLZ),  32'((q.size() > 0) && (hz == ZMAXV)));
    check("count",  32'(COUNT),  32'(q.size()));
    check("full",   32'(FULL),   32'(q.size() == DEPTH));
    check("drops",  32'(DROPS),  32'(m_drops));
    check("err",    32'(ERR),    32'(m_err));
`ifdef LZC_STATS_EN
    check("zmin",   32'(ZMIN),   32'(m_zmin));
    check("zmax",   32'(ZMAX),   32'(m_zmax));
    check("nres",   32'(NRES),   32'(m_nres));
`else
    check("zmin",   32'(ZMIN),   32'(ZMAXV));
    check("zmax",   32'(ZMAX),   32'(0));
    check("nres",   32'(NRES),   32'(0));
`endif
  endtask

  // Drive inputs, take one clock edge, advance the model, then compare.
  task automatic step(input bit iv, input int z, input bit rdy, input bit clr);
    IVALID = iv;
    ZEROS  = 9'(z);
    OREADY = rdy;
    CLR    = clr;
    @(posedge CLK);
    model_edge(iv, z, rdy, clr);
    #1;
    check_all();
  endtask

  initial begin
    RST_N  = 1'b0;
    IVALID = 1'b0;
    ZEROS  = 9'd0;
    OREADY = 1'b0;
    CLR    = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_all();
    check("rst_count_const", 32'(COUNT), 32'd0);
    RST_N = 1'b1;

    // push 3, 7, 16 with the consumer stalled
    step(1, 3, 0, 0);
    step(1, 7, 0, 0);
    step(1, 16, 0, 0);
    check("tp1_count", 32'(COUNT), 32'd3);
    check("tp1_head", 32'(OZEROS), 32'd3);
    step(0, 0, 1, 0);
    check("tp1_pop2", 32'(OZEROS), 32'd7);
    step(0, 0, 1, 0);
    check("tp1_allz", 32'(OALLZ), 32'd1);
    step(0, 0, 1, 0);
    check("tp1_empty", 32'(OVALID), 32'd0);

    // six pushes into a four-deep FIFO, then drain
    for (int i = 0; i < 6; i++) step(1, i + 1, 0, 0);
    check("tp2_drops", 32'(DROPS), 32'd2);
    check("tp2_full", 32'(FULL), 32'd1);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0);

    // refill, then push and pop together at full for five cycles
    for (int i = 0; i < 4; i++) step(1, 10 + i, 0, 0);
    for (int i = 0; i < 5; i++) step(1, i, 1, 0);
    check("tp3_count", 32'(COUNT), 32'd4);
    check("tp3_drops", 32'(DROPS), 32'd2);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0);

    // out-of-range counts clamp and set sticky ERR
    step(1, 20, 0, 0);
    check("tp4_oz", 32'(OZEROS), 32'd16);
    check("tp4_err", 32'(ERR), 32'd1);
    step(1, 300, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    check("tp4_err_hold", 32'(ERR), 32'd1);
    step(0, 0, 0, 1);
    check("tp4_err_clr", 32'(ERR), 32'd0);

    // statistics
    step(1, 5, 0, 0);
    step(1, 2, 0, 0);
    step(1, 9, 0, 0);

    // empty with a pop request and a push in the same cycle
    step(0, 0, 0, 1);
    step(1, 4, 1, 0);
    check("empty_pushpop", 32'(COUNT), 32'd1);

    // asynchronous reset between edges with two entries buffered
    step(1, 6, 0, 0);
    #2;
    RST_N = 1'b0;
    #1;
    model_reset();
    check_all();
    check("arst_ovalid", 32'(OVALID), 32'd0);
    #2;
    RST_N = 1'b1;

    // CLR with a concurrent strobe at full occupancy
    for (int i = 0; i < 5; i++) step(1, 8, 0, 0);
    step(1, 8, 1, 1);
    check("clr_count", 32'(COUNT), 32'd0);
    check("clr_drops", 32'(DROPS), 32'd0);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(99, 0) < 70), int'($urandom_range(20, 0)),
           ($urandom_range(99, 0) < 50), ($urandom_range(99, 0) < 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
